seq_arith_unit: RTL and testbench

//  Parametrised, registered arithmetic unit: add-with-carry, subtract-with-borrow,

---
 rtl/seq_arith_unit.sv | 134 +++++++++++++
 tb/tb_seq_arith_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// Registered arithmetic unit: ADD with carry, SUB with borrow, unsigned GEQ and a
// WIDTH-step shift-add multiplier, with valid/ready handshakes on both sides.
module seq_arith_unit #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 ci,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 co
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpGeq = 2'b11;

  typedef enum logic [1:0] {StIdle, StMulRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 co_q, co_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [2*WIDTH-1:0]   acc_next;

  // Single-cycle datapath results and the next multiplier accumulator value
  always_comb begin
    add_sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    // The extra MSB of the widened difference is exactly the borrow (x < y)
    sub_diff = {1'b0, x} - {1'b0, y};
    acc_next = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
  end

  // Next-state logic for the FSM, result registers and multiplier datapath
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    co_d     = co_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StDone;
          unique case (op)
            OpAdd: begin
              res_d = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
              co_d  = add_sum[WIDTH];
            end
            OpSub: begin
              res_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
              co_d  = sub_diff[WIDTH];
            end
            OpGeq: begin
              res_d = {{(2*WIDTH-1){1'b0}}, (x >= y)};
              co_d  = 1'b0;
            end
            OpMul: begin
              state_d  = StMulRun;
              mcand_d  = {{WIDTH{1'b0}}, x};
              mplier_d = y;
              acc_d    = '0;
              cnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
      StMulRun: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last of WIDTH steps: publish the completed product
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StDone;
          res_d   = acc_next;
          co_d    = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      res_q    <= '0;
      co_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      co_q     <= co_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs come straight from registers; no input-to-output combinational path
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    res       = res_q;
    co        = co_q;
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Self-checking bench for seq_arith_unit: directed scenarios on WIDTH=8 plus a
// randomized producer/consumer regression on WIDTH=8 and WIDTH=16 against a model.
module tb_seq_arith_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;          // 0: drive the 8-bit unit, 1: drive the 16-bit unit
  logic        in_valid;
  logic [1:0]  op;
  logic [15:0] x, y;
  logic        ci;
  logic        out_ready;

  logic        in_ready8, out_valid8, co8;
  logic [15:0] res8;
  logic        in_ready16, out_valid16, co16;
  logic [31:0] res16;

  logic        in_ready_m, out_valid_m, co_m;
  logic [31:0] res_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_arith_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel),
    .in_ready  (in_ready8),
    .op        (op),
    .x         (x[7:0]),
    .y         (y[7:0]),
    .ci        (ci),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .res       (res8),
    .co        (co8)
  );

  seq_arith_unit #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel),
    .in_ready  (in_ready16),
    .op        (op),
    .x         (x),
    .y         (y),
    .ci        (ci),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .res       (res16),
    .co        (co16)
  );

  always_comb begin
    in_ready_m  = sel ? in_ready16  : in_ready8;
    out_valid_m = sel ? out_valid16 : out_valid8;
    co_m        = sel ? co16        : co8;
    res_m       = sel ? res16       : {16'h0000, res8};
  end

  // Reference model straight from the arithmetic definitions
  function automatic void model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic c, input int w,
                                output logic [31:0] r, output logic cc);
    longint unsigned s, m;
    m = (64'd1 << w) - 1;
    case (o)
      2'b00: begin s = longint'(a) + longint'(b) + longint'(c); r = 32'(s & m);
                   cc = ((s >> w) & 1) != 0; end
      2'b01: begin s = longint'(a) - longint'(b); r = 32'(s & m); cc = (a < b); end
      2'b10: begin s = longint'(a) * longint'(b); r = 32'(s); cc = 1'b0; end
      default: begin r = (a >= b) ? 32'd1 : 32'd0; cc = 1'b0; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for its result (lat = -1 on timeout), then drain it
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic c, output logic [31:0] r, output logic cc, output int lat);
    int k;
    k = 0;
    while (!in_ready_m && k < 100) begin tick(); k++; end
    op = o; x = a; y = b; ci = c; in_valid = 1'b1;
    tick();
    // Scramble inputs after accept: the unit must have sampled them already
    in_valid = 1'b0; op = 2'($urandom); x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
    lat = 1;
    while (!out_valid_m && lat < 100) begin tick(); lat++; end
    r = res_m; cc = co_m;
    if (!out_valid_m) lat = -1;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    n_tests++;
    if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || res_m !== 32'd0 || co_m !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b res=%h co=%b, required 1 0 0 0",
               in_ready_m, out_valid_m, res_m, co_m);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_add();
    logic [31:0] r; logic cc; int lat;
    do_op(2'b00, 16'h00FF, 16'h0001, 1'b1, r, cc, lat);
    n_tests++;
    if (lat !== 1 || r !== 32'h0001 || cc !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ff_01_ci: lat=%0d res=%h co=%b, required 1 0001 1", lat, r, cc);
    end
  endtask

  task automatic test_sub();
    logic [31:0] r; logic cc; int lat;
    do_op(2'b01, 16'h0000, 16'h0001, 1'b0, r, cc, lat);
    n_tests++;
    if (lat !== 1 || r !== 32'h00FF || cc !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_0_1: lat=%0d res=%h co=%b, required 1 00ff 1", lat, r, cc);
    end
    do_op(2'b01, 16'h0005, 16'h0003, 1'b1, r, cc, lat);
    n_tests++;
    if (lat !== 1 || r !== 32'h0002 || cc !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_5_3: lat=%0d res=%h co=%b, required 1 0002 0", lat, r, cc);
    end
  endtask

  task automatic test_geq();
    logic [31:0] r; logic cc; int lat;
    do_op(2'b11, 16'h0080, 16'h0080, 1'b1, r, cc, lat);
    n_tests++;
    if (lat !== 1 || r !== 32'd1 || cc !== 1'b0) begin
      n_fail++;
      $display("FAIL geq_eq: lat=%0d res=%h co=%b, required 1 1 0", lat, r, cc);
    end
    do_op(2'b11, 16'h007F, 16'h0080, 1'b0, r, cc, lat);
    n_tests++;
    if (lat !== 1 || r !== 32'd0 || cc !== 1'b0) begin
      n_fail++;
      $display("FAIL geq_lt: lat=%0d res=%h co=%b, required 1 0 0", lat, r, cc);
    end
  endtask

  task automatic test_mul();
    int bad;
    bad = 0;
    op = 2'b10; x = 16'h00FF; y = 16'h00FF; ci = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; x = 16'h0000; y = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (out_valid_m !== 1'b0 || in_ready_m !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_busy: %0d cycles with out_valid/in_ready wrong, required 0", bad);
    end
    n_tests++;
    if (out_valid_m !== 1'b1 || res_m !== 32'hFE01 || co_m !== 1'b0 || in_ready_m !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_ff_ff: out_valid=%b res=%h co=%b in_ready=%b, required 1 fe01 0 0",
               out_valid_m, res_m, co_m, in_ready_m);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    op = 2'b10; x = 16'h000C; y = 16'h000A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) begin
      if (out_valid_m !== 1'b1 || res_m !== 32'h0078 || co_m !== 1'b0 || in_ready_m !== 1'b0)
        bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d cycles not holding 0078 with in_ready=0, required 0",
               bad);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_tests++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1",
               out_valid_m, in_ready_m);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r; logic cc; int lat; int bad;
    op = 2'b10; x = 16'h00FF; y = 16'h00FF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || res_m !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: out_valid=%b in_ready=%b res=%h, required 0 1 0",
               out_valid_m, in_ready_m, res_m);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid_m !== 1'b0) bad++;
      tick();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_mul_no_result: out_valid seen %0d cycles, required 0", bad);
    end
    do_op(2'b00, 16'h0001, 16'h0001, 1'b0, r, cc, lat);
    n_tests++;
    if (lat !== 1 || r !== 32'h0002 || cc !== 1'b0) begin
      n_fail++;
      $display("FAIL add_after_reset: lat=%0d res=%h co=%b, required 1 0002 0", lat, r, cc);
    end
  endtask

  // Concurrent producer/consumer with random in_valid gaps and out_ready toggling
  task automatic test_random(input int w);
    logic [31:0] exp_r[$];
    logic        exp_c[$];
    int          n;
    logic [15:0] mask;
    n    = 50;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    sel  = (w == 16);
    tick();
    fork
      begin : producer
        for (int i = 0; i < n; i++) begin
          logic [1:0] o; logic [15:0] a, b; logic c; logic [31:0] r; logic cc;
          logic acc; int k;
          o = 2'($urandom); a = 16'($urandom) & mask; b = 16'($urandom) & mask;
          c = 1'($urandom);
          if ($urandom_range(0, 3) == 0) begin a = mask; b = ($urandom_range(0, 1) == 0) ? mask : 16'd0; end
          model(o, a, b, c, w, r, cc);
          exp_r.push_back(r); exp_c.push_back(cc);
          op = o; x = a; y = b; ci = c; in_valid = 1'b1;
          k = 0;
          do begin acc = in_ready_m; tick(); k++; end while (!acc && k < 200);
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin : consumer
        for (int i = 0; i < n; i++) begin
          int k; logic done; logic held; logic [31:0] hr; logic hc;
          k = 0; done = 1'b0; held = 1'b0; hr = '0; hc = 1'b0;
          while (!done && k < 200) begin
            out_ready = ($urandom_range(0, 2) == 0);
            if (out_valid_m) begin
              if (held) begin
                n_tests++;
                if (res_m !== hr || co_m !== hc) begin
                  n_fail++;
                  $display("FAIL rand_w%0d_hold #%0d: res=%h co=%b, required %h %b",
                           w, i, res_m, co_m, hr, hc);
                end
              end
              held = 1'b1; hr = res_m; hc = co_m;
              if (out_ready) begin
                n_tests++;
                if (exp_r.size() == 0) begin
                  n_fail++;
                  $display("FAIL rand_w%0d #%0d: result res=%h with no request pending",
                           w, i, res_m);
                end else begin
                  logic [31:0] er; logic ec;
                  er = exp_r.pop_front(); ec = exp_c.pop_front();
                  if (res_m !== er || co_m !== ec) begin
                    n_fail++;
                    $display("FAIL rand_w%0d #%0d: res=%h co=%b, required %h %b",
                             w, i, res_m, co_m, er, ec);
                  end
                end
                done = 1'b1;
              end
            end
            tick();
            k++;
          end
          if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL rand_w%0d_timeout #%0d: out_valid=%b, required 1 within 200 cycles",
                     w, i, out_valid_m);
            break;
          end
        end
        out_ready = 1'b0;
      end
    join
    tick();
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; op = 2'b00; x = '0; y = '0; ci = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_geq();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random(8);
    test_random(16);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
